// File: rtl/stack_cmd_seq.sv
// stack_cmd_seq
//
// Command sequencer sitting in front of a pair of 8-bit LIFO stacks that share
// one select line. A single command is taken over a valid/ready handshake.
// Compound operations (DUP, SWAP, MOVE, CLEAR) are expanded into a short run of
// push/pop strobes. Exactly one response is returned per accepted command.
//
// Ports
//   clk, rst_n         clock (rising edge), synchronous active-low reset
//   cmd_valid/ready    command handshake; ready is high only while idle
//   cmd_op/sel/data    opcode (NOP PUSH POP PEEK DUP SWAP MOVE CLEAR),
//                      target stack (source for MOVE), PUSH operand
//   rsp_valid          one-cycle completion pulse
//   rsp_data/err       result and error flag, held until the next response
//   stk_select         shared stack select
//   stk_push/pop       push / pop strobes, never both high
//   stk_wdata          push data
//   stk_rdata          top of the currently selected stack (0 when empty)
//   stk_empty/full     per-stack status, bit i = stack i
module stack_cmd_seq #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic       cmd_sel,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic       stk_select,
    output logic       stk_push,
    output logic       stk_pop,
    output logic [7:0] stk_wdata,
    input  logic [7:0] stk_rdata,
    input  logic [1:0] stk_empty,
    input  logic [1:0] stk_full
);

    // CLEAR can remove at most DEPTH items, so the counter holds 0..DEPTH.
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP
    } state_t;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_PUSH  = 3'd1,
        OP_POP   = 3'd2,
        OP_PEEK  = 3'd3,
        OP_DUP   = 3'd4,
        OP_SWAP  = 3'd5,
        OP_MOVE  = 3'd6,
        OP_CLEAR = 3'd7
    } op_t;

    state_t           state_q;
    logic [1:0]       step_q;
    op_t              op_q;
    logic             sel_q;
    logic [7:0]       data_q;
    logic [7:0]       t0_q;
    logic [7:0]       t1_q;
    logic [CNT_W-1:0] count_q;
    logic             rsp_valid_q;
    logic [7:0]       rsp_data_q;
    logic             rsp_err_q;

    // Status of the latched target stack and of the other stack.
    logic empty_s;
    logic full_s;
    logic full_o;

    assign empty_s = stk_empty[sel_q];
    assign full_s  = stk_full[sel_q];
    assign full_o  = stk_full[~sel_q];

    // Per-cycle EXEC outcome: finish (with data/err), temp loads, CLEAR count.
    logic       fin;
    logic       fin_err;
    logic [7:0] fin_data;
    logic       ld_t0;
    logic       ld_t1;
    logic       cnt_inc;

    always_comb begin
        fin      = 1'b0;
        fin_err  = 1'b0;
        fin_data = 8'h00;
        ld_t0    = 1'b0;
        ld_t1    = 1'b0;
        cnt_inc  = 1'b0;
        unique case (op_q)
            OP_NOP: begin
                fin = 1'b1;
            end
            OP_PUSH: begin
                fin = 1'b1;
                if (full_s) fin_err  = 1'b1;
                else        fin_data = data_q;
            end
            OP_POP, OP_PEEK: begin
                fin = 1'b1;
                if (empty_s) fin_err  = 1'b1;
                else         fin_data = stk_rdata;
            end
            OP_DUP: begin
                if (step_q == 2'd0) begin
                    if (empty_s || full_s) begin
                        fin     = 1'b1;
                        fin_err = 1'b1;
                    end else begin
                        ld_t0 = 1'b1;
                    end
                end else begin
                    fin      = 1'b1;
                    fin_data = t0_q;
                end
            end
            OP_SWAP: begin
                unique case (step_q)
                    2'd0: begin
                        if (empty_s) begin
                            fin     = 1'b1;
                            fin_err = 1'b1;
                        end else begin
                            ld_t0 = 1'b1;
                        end
                    end
                    2'd1: begin
                        // Stack held a single entry: it gets restored below.
                        if (empty_s) begin
                            fin     = 1'b1;
                            fin_err = 1'b1;
                        end else begin
                            ld_t1 = 1'b1;
                        end
                    end
                    2'd2: begin
                    end
                    default: begin
                        fin      = 1'b1;
                        fin_data = t1_q;
                    end
                endcase
            end
            OP_MOVE: begin
                if (step_q == 2'd0) begin
                    if (empty_s || full_o) begin
                        fin     = 1'b1;
                        fin_err = 1'b1;
                    end else begin
                        ld_t0 = 1'b1;
                    end
                end else begin
                    fin      = 1'b1;
                    fin_data = t0_q;
                end
            end
            default: begin
                // CLEAR: pop until the stack reports empty.
                if (empty_s) begin
                    fin      = 1'b1;
                    fin_data = 8'(count_q);
                end else begin
                    cnt_inc = 1'b1;
                end
            end
        endcase
    end

    // Strobe decode. Strobes are gated by the flags of the same cycle so that
    // an error exit never disturbs the stacks; the stacks act on the next edge.
    logic       sel_eff;
    logic       push_c;
    logic       pop_c;
    logic [7:0] wdata_c;

    always_comb begin
        sel_eff = sel_q;
        push_c  = 1'b0;
        pop_c   = 1'b0;
        wdata_c = 8'h00;
        if (state_q == S_EXEC) begin
            unique case (op_q)
                OP_PUSH: begin
                    if (!full_s) begin
                        push_c  = 1'b1;
                        wdata_c = data_q;
                    end
                end
                OP_POP: begin
                    pop_c = !empty_s;
                end
                OP_DUP: begin
                    if (step_q == 2'd1) begin
                        push_c  = 1'b1;
                        wdata_c = t0_q;
                    end
                end
                OP_SWAP: begin
                    unique case (step_q)
                        2'd0: pop_c = !empty_s;
                        2'd1: begin
                            if (empty_s) begin
                                push_c  = 1'b1;
                                wdata_c = t0_q;
                            end else begin
                                pop_c = 1'b1;
                            end
                        end
                        2'd2: begin
                            push_c  = 1'b1;
                            wdata_c = t0_q;
                        end
                        default: begin
                            push_c  = 1'b1;
                            wdata_c = t1_q;
                        end
                    endcase
                end
                OP_MOVE: begin
                    if (step_q == 2'd0) begin
                        pop_c = !(empty_s || full_o);
                    end else begin
                        sel_eff = ~sel_q;
                        push_c  = 1'b1;
                        wdata_c = t0_q;
                    end
                end
                OP_CLEAR: begin
                    pop_c = !empty_s;
                end
                default: begin
                end
            endcase
        end
    end

    assign cmd_ready  = (state_q == S_IDLE);
    assign stk_select = (state_q == S_EXEC) ? sel_eff : 1'b0;
    assign stk_push   = push_c;
    assign stk_pop    = pop_c;
    assign stk_wdata  = wdata_c;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_err    = rsp_err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            step_q      <= 2'd0;
            op_q        <= OP_NOP;
            sel_q       <= 1'b0;
            data_q      <= 8'h00;
            t0_q        <= 8'h00;
            t1_q        <= 8'h00;
            count_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_q    <= op_t'(cmd_op);
                        sel_q   <= cmd_sel;
                        data_q  <= cmd_data;
                        count_q <= '0;
                        step_q  <= 2'd0;
                        // NOP has nothing to execute and responds immediately.
                        if (op_t'(cmd_op) == OP_NOP) begin
                            state_q     <= S_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= 8'h00;
                            rsp_err_q   <= 1'b0;
                        end else begin
                            state_q <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    if (ld_t0)   t0_q    <= stk_rdata;
                    if (ld_t1)   t1_q    <= stk_rdata;
                    if (cnt_inc) count_q <= count_q + 1'b1;
                    step_q <= step_q + 2'd1;
                    if (fin) begin
                        state_q     <= S_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= fin_data;
                        rsp_err_q   <= fin_err;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
